// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types for the two-requester AXI read arbiter.
// FSM encoding and requester indices.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// One AXI4 read port (AR + R channels).
// master drives AR and RREADY; slave answers.
interface axi_rd_arbiter_if #(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32,
  parameter int C_M_AXI_ARUSER_WIDTH    = 1,
  parameter int C_M_AXI_RUSER_WIDTH     = 4
);

  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] arid;
  logic [C_M_AXI_ADDR_WIDTH-1:0]      araddr;
  logic [7:0]                         arlen;
  logic [2:0]                         arsize;
  logic [1:0]                         arburst;
  logic [1:0]                         arlock;
  logic [3:0]                         arcache;
  logic [2:0]                         arprot;
  logic [3:0]                         arqos;
  logic [C_M_AXI_ARUSER_WIDTH-1:0]    aruser;
  logic                               arvalid;
  logic                               arready;

  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] rid;
  logic [C_M_AXI_DATA_WIDTH-1:0]      rdata;
  logic [1:0]                         rresp;
  logic                               rlast;
  logic [C_M_AXI_RUSER_WIDTH-1:0]     ruser;
  logic                               rvalid;
  logic                               rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arqos, aruser,
    output arvalid, rready,
    input  arready, rid, rdata, rresp, rlast,
    input  ruser, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arqos, aruser,
    input  arvalid, rready,
    output arready, rid, rdata, rresp, rlast,
    output ruser, rvalid
  );

endinterface

// File: rtl/axi_rd_arbiter_rr_pick2.sv
// Two-way round-robin picker.
// On a tie the side not granted last time wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (req == 2'b11): grant = ~last;
      (req == 2'b10): grant = 1'b1;
      default:        grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master between inst-fetch (s0)
// and data-load (s1); one burst outstanding at a time.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32,
  parameter int C_M_AXI_ARUSER_WIDTH    = 1,
  parameter int C_M_AXI_RUSER_WIDTH     = 4
) (
  input logic              CLK,
  input logic              RST,
  axi_rd_arbiter_if.slave  s0,
  axi_rd_arbiter_if.slave  s1,
  axi_rd_arbiter_if.master m
);

  state_t state;
  logic   grant;
  logic   last;
  logic   pick;
  logic   in_addr;
  logic   in_data;
  logic   sel_data;

  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] ar_id;
  logic [C_M_AXI_ADDR_WIDTH-1:0]      ar_addr;
  logic [7:0]                         ar_len;
  logic [2:0]                         ar_size;
  logic [1:0]                         ar_burst;
  logic [1:0]                         ar_lock;
  logic [3:0]                         ar_cache;
  logic [2:0]                         ar_prot;
  logic [3:0]                         ar_qos;
  logic [C_M_AXI_ARUSER_WIDTH-1:0]    ar_user;
  logic                               ar_valid;
  logic [C_M_AXI_DATA_WIDTH-1:0]      r_data;
  logic [C_M_AXI_RUSER_WIDTH-1:0]     r_user;

  rr_pick2 u_pick (
    .req   ({s1.arvalid, s0.arvalid}),
    .last  (last),
    .grant (pick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      grant <= REQ_INST;
      last  <= REQ_DATA;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (s0.arvalid | s1.arvalid) begin
            grant <= pick;
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m.arvalid & m.arready)
            state <= ST_DATA;
        end
        ST_DATA: begin
          if (m.rvalid & m.rready & m.rlast) begin
            last  <= grant;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_addr  = (state == ST_ADDR);
  assign in_data  = (state == ST_DATA);
  assign sel_data = (grant == REQ_DATA);

  // Payload is forced to zero whenever no address phase is open.
  always_comb begin
    ar_id    = '0;
    ar_addr  = '0;
    ar_len   = '0;
    ar_size  = '0;
    ar_burst = '0;
    ar_lock  = '0;
    ar_cache = '0;
    ar_prot  = '0;
    ar_qos   = '0;
    ar_user  = '0;
    ar_valid = 1'b0;
    if (in_addr) begin
      if (sel_data) begin
        ar_id    = s1.arid;
        ar_addr  = s1.araddr;
        ar_len   = s1.arlen;
        ar_size  = s1.arsize;
        ar_burst = s1.arburst;
        ar_lock  = s1.arlock;
        ar_cache = s1.arcache;
        ar_prot  = s1.arprot;
        ar_qos   = s1.arqos;
        ar_user  = s1.aruser;
        ar_valid = s1.arvalid;
      end else begin
        ar_id    = s0.arid;
        ar_addr  = s0.araddr;
        ar_len   = s0.arlen;
        ar_size  = s0.arsize;
        ar_burst = s0.arburst;
        ar_lock  = s0.arlock;
        ar_cache = s0.arcache;
        ar_prot  = s0.arprot;
        ar_qos   = s0.arqos;
        ar_user  = s0.aruser;
        ar_valid = s0.arvalid;
      end
    end
  end

  assign m.arid    = ar_id;
  assign m.araddr  = ar_addr;
  assign m.arlen   = ar_len;
  assign m.arsize  = ar_size;
  assign m.arburst = ar_burst;
  assign m.arlock  = ar_lock;
  assign m.arcache = ar_cache;
  assign m.arprot  = ar_prot;
  assign m.arqos   = ar_qos;
  assign m.aruser  = ar_user;
  assign m.arvalid = ar_valid;

  assign s0.arready = in_addr & ~sel_data & m.arready;
  assign s1.arready = in_addr &  sel_data & m.arready;

  // R payload fans out to both; only RVALID selects the owner.
  assign r_data = m.rdata;
  assign r_user = m.ruser;

  assign s0.rid   = m.rid;
  assign s0.rdata = r_data;
  assign s0.rresp = m.rresp;
  assign s0.rlast = m.rlast;
  assign s0.ruser = r_user;
  assign s1.rid   = m.rid;
  assign s1.rdata = r_data;
  assign s1.rresp = m.rresp;
  assign s1.rlast = m.rlast;
  assign s1.ruser = r_user;

  assign s0.rvalid = in_data & ~sel_data & m.rvalid;
  assign s1.rvalid = in_data &  sel_data & m.rvalid;
  assign m.rready  = in_data &
                     (sel_data ? s1.rready : s0.rready);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed bursts,
// a small AXI slave model and negedge monitors.
module tb_axi_rd_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  axi_rd_arbiter_if s0 ();
  axi_rd_arbiter_if s1 ();
  axi_rd_arbiter_if m ();

  axi_rd_arbiter dut (
    .CLK (CLK),
    .RST (RST),
    .s0  (s0),
    .s1  (s1),
    .m   (m)
  );

  typedef struct packed {
    logic        req;
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        id;
  } ar_t;

  beat_t exp_b[$];
  ar_t   exp_a[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nbeats = 0;
  int arv_rise = 0;
  int rlast_cyc [2] = '{0, 0};

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               nm, got, want);
    end
  endtask

  // requester side stimulus
  logic        rq_v [2];
  logic [31:0] rq_a [2];
  logic [7:0]  rq_l [2];
  logic        rdy  [2] = '{1'b1, 1'b1};
  logic        toggle = 1'b0;

  assign s0.arvalid = rq_v[0];
  assign s0.araddr  = rq_a[0];
  assign s0.arlen   = rq_l[0];
  assign s0.arid    = 1'b0;
  assign s0.arsize  = 3'd2;
  assign s0.arburst = 2'b01;
  assign s0.arlock  = 2'b00;
  assign s0.arcache = 4'h3;
  assign s0.arprot  = 3'b100;
  assign s0.arqos   = 4'h0;
  assign s0.aruser  = 1'b0;
  assign s0.rready  = rdy[0];

  assign s1.arvalid = rq_v[1];
  assign s1.araddr  = rq_a[1];
  assign s1.arlen   = rq_l[1];
  assign s1.arid    = 1'b1;
  assign s1.arsize  = 3'd2;
  assign s1.arburst = 2'b01;
  assign s1.arlock  = 2'b00;
  assign s1.arcache = 4'hf;
  assign s1.arprot  = 3'b000;
  assign s1.arqos   = 4'h1;
  assign s1.aruser  = 1'b1;
  assign s1.rready  = rdy[1];

  function automatic logic [18:0] attr(input logic n);
    if (n) return {3'd2, 2'b01, 2'b00, 4'hf, 3'b000, 4'h1, 1'b1};
    return {3'd2, 2'b01, 2'b00, 4'h3, 3'b100, 4'h0, 1'b0};
  endfunction

  always begin
    @(posedge CLK);
    #1;
    rdy[0] = toggle ? ~rdy[0] : 1'b1;
    rdy[1] = 1'b1;
  end

  // AXI slave model behind the arbiter: data = addr + beat
  logic        busy = 1'b0;
  logic [7:0]  beat = 8'd0;
  logic [7:0]  blen = 8'd0;
  logic [31:0] base = 32'd0;
  logic        bid  = 1'b0;
  int          wcnt = 0;
  int          ar_delay = 0;
  logic        s_rst, s_arhs, s_rhs, s_wait, s_id;
  logic [31:0] s_addr;
  logic [7:0]  s_len;

  assign m.arready = !busy && (wcnt >= ar_delay);
  assign m.rvalid  = busy;
  assign m.rdata   = base + {24'd0, beat};
  assign m.rlast   = busy && (beat == blen);
  assign m.rid     = bid;
  assign m.rresp   = 2'b00;
  assign m.ruser   = 4'h0;

  always begin
    @(negedge CLK);
    s_rst  = RST;
    s_arhs = m.arvalid && m.arready;
    s_rhs  = m.rvalid && m.rready;
    s_wait = m.arvalid && !m.arready;
    s_addr = m.araddr;
    s_len  = m.arlen;
    s_id   = m.arid;
    @(posedge CLK);
    #1;
    if (s_rst) begin
      busy = 1'b0;
      beat = 8'd0;
      wcnt = 0;
    end else begin
      if (s_wait) wcnt++;
      if (s_arhs) begin
        busy = 1'b1;
        beat = 8'd0;
        wcnt = 0;
        base = s_addr;
        blen = s_len;
        bid  = s_id;
      end else if (s_rhs) begin
        if (beat == blen) busy = 1'b0;
        else beat = beat + 8'd1;
      end
    end
  end

  // monitors
  logic        arv_q = 1'b0;
  logic        mv  [2];
  logic        mr  [2];
  logic        ml  [2];
  logic        mid [2];
  logic [31:0] md  [2];
  logic [5:0]  mru [2];
  ar_t         ea;
  beat_t       eb;

  always begin
    @(negedge CLK);
    if (RST) begin
      arv_q = 1'b0;
    end else begin
      if (m.arvalid && m.arready) begin
        chk("ar_expected", 64'(exp_a.size() > 0), 64'd1);
        if (exp_a.size() > 0) begin
          ea = exp_a.pop_front();
          chk("ar_addr", 64'(m.araddr), 64'(ea.addr));
          chk("ar_len", 64'(m.arlen), 64'(ea.len));
          chk("ar_id", 64'(m.arid), 64'(ea.id));
          chk("ar_attr",
              64'({m.arsize, m.arburst, m.arlock, m.arcache,
                   m.arprot, m.arqos, m.aruser}),
              64'(attr(ea.id)));
        end
      end
      if (m.arvalid && !arv_q) arv_rise = cyc;
      arv_q = m.arvalid;

      if (busy && (rq_v[0] || rq_v[1]))
        chk("arready_in_data",
            64'({s1.arready, s0.arready}), 64'd0);
      if (busy && exp_b.size() > 0)
        chk("m_rready", 64'(m.rready),
            64'(rdy[exp_b[0].req]));

      mv[0] = s0.rvalid;  mv[1] = s1.rvalid;
      mr[0] = s0.rready;  mr[1] = s1.rready;
      ml[0] = s0.rlast;   ml[1] = s1.rlast;
      mid[0] = s0.rid;    mid[1] = s1.rid;
      md[0] = s0.rdata;   md[1] = s1.rdata;
      mru[0] = {s0.rresp, s0.ruser};
      mru[1] = {s1.rresp, s1.ruser};
      for (int n = 0; n < 2; n++) begin
        if (mv[n]) begin
          chk("r_expected", 64'(exp_b.size() > 0), 64'd1);
          if (exp_b.size() > 0) begin
            chk("r_owner", 64'(n), 64'(exp_b[0].req));
            if (mr[n]) begin
              eb = exp_b.pop_front();
              nbeats++;
              chk("r_data", 64'(md[n]), 64'(eb.data));
              chk("r_last", 64'(ml[n]), 64'(eb.last));
              chk("r_id", 64'(mid[n]), 64'(n));
              chk("r_resp_user", 64'(mru[n]), 64'd0);
              if (ml[n]) rlast_cyc[n] = cyc;
            end
          end
        end
      end
    end
  end

  // stimulus helpers
  task automatic exp_burst(input logic n,
                           input logic [31:0] a,
                           input logic [7:0] l);
    exp_a.push_back('{addr: a, len: l, id: n});
    for (int i = 0; i <= int'(l); i++)
      exp_b.push_back('{req: n, data: a + 32'(i),
                        last: (i == int'(l))});
  endtask

  task automatic req(input int n,
                     input logic [31:0] a,
                     input logic [7:0] l);
    logic done;
    @(posedge CLK);
    #1;
    rq_a[n] = a;
    rq_l[n] = l;
    rq_v[n] = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge CLK);
      done = (n == 1) ? s1.arready : s0.arready;
      @(posedge CLK);
      #1;
    end
    rq_v[n] = 1'b0;
    chk("req_granted", 64'(done), 64'd1);
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (k < 200 && (busy || exp_b.size() != 0 ||
                       exp_a.size() != 0)) begin
      @(negedge CLK);
      k++;
    end
    chk({nm, "_drained"}, 64'(k < 200), 64'd1);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_hs"},
        64'({m.arvalid, m.rready, s0.arready, s1.arready,
             s0.rvalid, s1.rvalid}), 64'd0);
    chk({nm, "_payload"},
        64'({m.araddr, m.arlen, m.arid}), 64'd0);
  endtask

  task automatic wait_busy();
    int k;
    k = 0;
    while (k < 50 && !busy) begin
      @(negedge CLK);
      k++;
    end
    chk("wait_busy", 64'(busy), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int b0;

  initial begin
    rq_v[0] = 1'b0;  rq_v[1] = 1'b0;
    rq_a[0] = '0;    rq_a[1] = '0;
    rq_l[0] = '0;    rq_l[1] = '0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_idle("reset");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk_idle("post_reset");

    // ties after reset: S0, S1, then S0, S1 again
    exp_burst(1'b0, 32'h1000_0000, 8'd1);
    exp_burst(1'b1, 32'h3000_0000, 8'd2);
    fork
      req(0, 32'h1000_0000, 8'd1);
      req(1, 32'h3000_0000, 8'd2);
    join
    drain("tie1");
    exp_burst(1'b0, 32'h1100_0000, 8'd0);
    exp_burst(1'b1, 32'h3100_0000, 8'd1);
    fork
      req(0, 32'h1100_0000, 8'd0);
      req(1, 32'h3100_0000, 8'd1);
    join
    drain("tie2");

    // single S0 burst with ARREADY delayed
    ar_delay = 2;
    b0 = nbeats;
    exp_burst(1'b0, 32'h2000_0000, 8'd3);
    req(0, 32'h2000_0000, 8'd3);
    drain("single");
    chk("single_beats", 64'(nbeats - b0), 64'd4);
    chk_idle("single_idle");
    ar_delay = 0;

    // S1 arrives during S0 data phase
    exp_burst(1'b0, 32'h4000_0000, 8'd3);
    exp_burst(1'b1, 32'h5000_0000, 8'd0);
    fork
      req(0, 32'h4000_0000, 8'd3);
      begin
        wait_busy();
        req(1, 32'h5000_0000, 8'd0);
      end
    join
    drain("late_s1");
    chk("late_s1_gap", 64'(arv_rise - rlast_cyc[0]), 64'd2);

    // RREADY backpressure over 8 beats
    toggle = 1'b1;
    b0 = nbeats;
    exp_burst(1'b0, 32'h6000_0000, 8'd7);
    req(0, 32'h6000_0000, 8'd7);
    drain("bp");
    chk("bp_beats", 64'(nbeats - b0), 64'd8);
    toggle = 1'b0;

    // reset on beat 2 of a 4-beat burst
    b0 = nbeats;
    exp_burst(1'b0, 32'h7000_0000, 8'd3);
    req(0, 32'h7000_0000, 8'd3);
    for (int k = 0; k < 50 && nbeats < b0 + 1; k++)
      @(negedge CLK);
    chk("rst_beat1_seen", 64'(nbeats - b0), 64'd1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_b.delete();
    exp_a.delete();
    @(negedge CLK);
    chk_idle("rst_mid");

    b0 = nbeats;
    exp_burst(1'b1, 32'h8000_0000, 8'd0);
    req(1, 32'h8000_0000, 8'd0);
    drain("after_rst");
    chk("after_rst_beats", 64'(nbeats - b0), 64'd1);
    chk_idle("final");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
